hilo_file: RTL and testbench
============================

Name: hilo_file

Overview:
Parametrised HI/LO special-register pair for the writeback stage. Supports independent HI and LO writes and a joint 2W-bit write. Adds multiply-accumulate modes (MADD/MSUB) that add or subtract an upstream 2W-bit product into {hi,lo}. Takes commands over a valid/ready handshake, with an optional 2-stage accumulate pipeline and flush cancellation for exceptions.

Parameters:
DATA_WIDTH, 32, width W of each of HI and LO.
PIPELINED_ACC, 1, 1 = accumulate commits one edge after acceptance; 0 = accumulate commits on the acceptance edge.
RESET_VALUE, 0, value loaded into both HI and LO on reset.

Ports:
clock  input  1  clock; all state updates on rising edge
reset  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  3  0 WRITE_HI, 1 WRITE_LO, 2 WRITE_BOTH, 3 MADD, 4 MSUB, 5-7 reserved
cmd_data_hi  input  DATA_WIDTH  HI write data / upper half of accumulate operand
cmd_data_lo  input  DATA_WIDTH  LO write data / lower half of accumulate operand
flush  input  1  cancel any uncommitted command
busy  output  1  accumulate pending in stage 2
hi_read_data  output  DATA_WIDTH  architectural HI
lo_read_data  output  DATA_WIDTH  architectural LO

Behaviour:
- Reset (synchronous, has priority over everything): hi_read_data = lo_read_data = RESET_VALUE; stage-2 valid cleared, so busy = 0; cmd_ready = 1 from the first cycle after reset.
- Acceptance: a command is accepted on an edge where cmd_valid & cmd_ready & !flush. If flush = 1 with cmd_valid = 1, the command is dropped with no state change.
- cmd_ready = !busy. Combinational from state only; never depends on cmd_valid.
- WRITE_HI: hi <= cmd_data_hi; LO unchanged.
- WRITE_LO: lo <= cmd_data_lo; HI unchanged.
- WRITE_BOTH: both halves written. All three write ops are visible on the read outputs the cycle after the accepting edge (1-cycle latency).
- MADD / MSUB: {hi,lo} <= {hi,lo} +/- {cmd_data_hi,cmd_data_lo}, modulo 2^(2W). Carry/borrow passes from LO into HI. No overflow flag; wrap is silent.
- Reserved ops: accepted as no-ops. No state change, and busy is not set.
- PIPELINED_ACC = 1, two-state FSM IDLE/ACC:
  - IDLE -> ACC on an accepted MADD/MSUB. The operand and add/sub select are captured into the stage-2 register; busy = 1 and cmd_ready = 0 during ACC.
  - ACC -> IDLE on the next edge. If flush = 0 in the ACC cycle, the result commits to {hi,lo}. If flush = 1, nothing commits.
  - Result is visible on the read outputs 2 cycles after acceptance. Throughput is one accumulate per 2 cycles.
- PIPELINED_ACC = 0: MADD/MSUB commit on the accepting edge, like writes. busy is tied 0 and cmd_ready is tied 1.
- The accumulate always reads the committed {hi,lo}. No hazard is possible because commands stall while busy.
- Reset asserted while busy: the pending accumulate is discarded and registers return to RESET_VALUE.
- Reset and flush together: reset wins; the result is identical either way.
- Read outputs are registered, with no combinational path from any input.

Decomposition:
- Package hilo_pkg: op encodings (OP_WRITE_HI..OP_MSUB), OP_WIDTH = 3, FSM state encoding (ST_IDLE, ST_ACC).
- One sub-module, hilo_acc_stage: operand/select capture register plus the 2W-bit add/sub. Instantiated only when PIPELINED_ACC = 1; otherwise a combinational adder is used in the top level.

Test Plan:
- Reset, W = 32: hold reset 2 cycles, then release -> hi = lo = 0x00000000, busy = 0, cmd_ready = 1.
- Back-to-back writes: WRITE_HI 0xDEADBEEF then WRITE_LO 0x12345678 on consecutive cycles -> hi = 0xDEADBEEF one cycle after the first edge; lo = 0x12345678 one cycle after the second; hi unchanged by the second write.
- MADD carry: WRITE_BOTH {0x00000000, 0xFFFFFFFF}, then MADD {0x0, 0x1} -> cmd_ready low for exactly 1 cycle; two edges after acceptance hi = 0x00000001, lo = 0x00000000.
- MSUB wrap and stall: from {0,0}, MSUB {0x0, 0x1} -> hi = lo = 0xFFFFFFFF. A WRITE_LO 0x5 held valid during busy is accepted only after busy falls, then lo = 0x5.
- Flush: MADD {0x0, 0x10} accepted, flush = 1 in the ACC cycle -> hi/lo unchanged, busy = 0 next cycle. Also cmd_valid + flush together on WRITE_HI -> no change.
- Reset mid-op and mode: assert reset during ACC -> hi = lo = 0, busy = 0. With PIPELINED_ACC = 0, MADD {0x0, 0x3} from {0x0, 0x2} -> lo = 0x5 one cycle after acceptance, busy never 1.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO special-register pair.
//   op_e     - command opcodes carried on cmd_op (5-7 are reserved no-ops)
//   state_e  - accumulate pipeline state (IDLE / ACC)
package hilo_pkg;

    localparam int unsigned OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_WRITE_HI   = 3'd0,
        OP_WRITE_LO   = 3'd1,
        OP_WRITE_BOTH = 3'd2,
        OP_MADD       = 3'd3,
        OP_MSUB       = 3'd4
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/hilo_acc_stage.sv
// hilo_acc_stage: stage-2 register of the accumulate pipeline.
//   clock, reset  - clock, synchronous active-high reset
//   capture       - load operand and add/sub select this edge
//   sub_in        - 1 = subtract (MSUB), 0 = add (MADD)
//   operand_in    - 2W-bit accumulate operand {hi,lo}
//   acc_in        - committed {hi,lo} to accumulate into
//   result        - acc_in +/- captured operand, modulo 2^(2W)
module hilo_acc_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      capture,
    input  logic                      sub_in,
    input  logic [2*DATA_WIDTH-1:0]   operand_in,
    input  logic [2*DATA_WIDTH-1:0]   acc_in,
    output logic [2*DATA_WIDTH-1:0]   result
);

    logic [2*DATA_WIDTH-1:0] operand_q;
    logic                    sub_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            operand_q <= '0;
            sub_q     <= 1'b0;
        end else if (capture) begin
            operand_q <= operand_in;
            sub_q     <= sub_in;
        end
    end

    // Full-width add/sub so carry and borrow cross from LO into HI.
    always_comb begin
        result = sub_q ? (acc_in - operand_q) : (acc_in + operand_q);
    end

endmodule

// File: rtl/hilo_file.sv
// hilo_file: HI/LO special-register pair with writes and MADD/MSUB.
//   clock, reset               - clock, synchronous active-high reset
//   cmd_valid / cmd_ready      - command handshake (cmd_ready = !busy)
//   cmd_op                     - opcode, see hilo_pkg::op_e
//   cmd_data_hi / cmd_data_lo  - write data or accumulate operand halves
//   flush                      - cancel the command in flight this cycle
//   busy                       - accumulate pending in stage 2
//   hi_read_data, lo_read_data - architectural HI / LO (registered)
module hilo_file
    import hilo_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter bit                     PIPELINED_ACC = 1'b1,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_WIDTH-1:0]    cmd_op,
    input  logic [DATA_WIDTH-1:0]  cmd_data_hi,
    input  logic [DATA_WIDTH-1:0]  cmd_data_lo,
    input  logic                   flush,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  hi_read_data,
    output logic [DATA_WIDTH-1:0]  lo_read_data
);

    logic [DATA_WIDTH-1:0]   hi_q;
    logic [DATA_WIDTH-1:0]   lo_q;
    state_e                  state;
    logic                    accept;
    logic                    is_acc;
    logic                    is_sub;
    logic [2*DATA_WIDTH-1:0] acc_result;

    assign accept = cmd_valid & cmd_ready & ~flush;
    assign is_acc = (cmd_op == OP_MADD) || (cmd_op == OP_MSUB);
    assign is_sub = (cmd_op == OP_MSUB);

    generate
        if (PIPELINED_ACC) begin : g_pipe
            hilo_acc_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_acc_stage (
                .clock      (clock),
                .reset      (reset),
                .capture    (accept & is_acc),
                .sub_in     (is_sub),
                .operand_in ({cmd_data_hi, cmd_data_lo}),
                .acc_in     ({hi_q, lo_q}),
                .result     (acc_result)
            );
            assign busy = (state == ST_ACC);
        end else begin : g_comb
            assign acc_result = is_sub ? ({hi_q, lo_q} - {cmd_data_hi, cmd_data_lo})
                                       : ({hi_q, lo_q} + {cmd_data_hi, cmd_data_lo});
            assign busy = 1'b0;
        end
    endgenerate

    assign cmd_ready = ~busy;

    // Commands stall while in ACC, so the stage-2 adder always sees the
    // same {hi,lo} that was committed when the accumulate was accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q  <= RESET_VALUE;
            lo_q  <= RESET_VALUE;
            state <= ST_IDLE;
        end else if (state == ST_ACC) begin
            state <= ST_IDLE;
            if (!flush) begin
                {hi_q, lo_q} <= acc_result;
            end
        end else if (accept) begin
            case (cmd_op)
                OP_WRITE_HI:   hi_q <= cmd_data_hi;
                OP_WRITE_LO:   lo_q <= cmd_data_lo;
                OP_WRITE_BOTH: begin
                    hi_q <= cmd_data_hi;
                    lo_q <= cmd_data_lo;
                end
                OP_MADD, OP_MSUB: begin
                    if (PIPELINED_ACC) begin
                        state <= ST_ACC;
                    end else begin
                        {hi_q, lo_q} <= acc_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_read_data = hi_q;
    assign lo_read_data = lo_q;

endmodule

// File: tb/tb_hilo_file.sv
module tb_hilo_file;

    localparam int W = 32;
    localparam logic [W-1:0] RV_C = 32'hA5A5_0F0F;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data_hi;
    logic [W-1:0] cmd_data_lo;
    logic         flush;

    logic         ready_p, busy_p, ready_c, busy_c;
    logic [W-1:0] hi_p, lo_p, hi_c, lo_c;

    int checks = 0;
    int errors = 0;

    // Reference: architectural value as one 2W-bit number plus a pending
    // accumulate (pipelined instance) that lands on the following edge.
    logic [2*W-1:0] mp, mc;
    logic           pend;
    logic           pend_sub;
    logic [2*W-1:0] pend_opnd;

    always #5 clock = ~clock;

    hilo_file #(.DATA_WIDTH(W), .PIPELINED_ACC(1'b1), .RESET_VALUE(32'h0)) u_pipe (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_p),
        .cmd_op(cmd_op), .cmd_data_hi(cmd_data_hi), .cmd_data_lo(cmd_data_lo),
        .flush(flush), .busy(busy_p), .hi_read_data(hi_p), .lo_read_data(lo_p)
    );

    hilo_file #(.DATA_WIDTH(W), .PIPELINED_ACC(1'b0), .RESET_VALUE(RV_C)) u_comb (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_c),
        .cmd_op(cmd_op), .cmd_data_hi(cmd_data_hi), .cmd_data_lo(cmd_data_lo),
        .flush(flush), .busy(busy_c), .hi_read_data(hi_c), .lo_read_data(lo_c)
    );

    task automatic set_cmd(input logic v, input logic [2:0] op,
                           input logic [W-1:0] dh, input logic [W-1:0] dl);
        cmd_valid   = v;
        cmd_op      = op;
        cmd_data_hi = dh;
        cmd_data_lo = dl;
    endtask

    // Advance one clock edge and update the reference from the inputs
    // that were applied during the cycle.
    task automatic tick();
        logic [2*W-1:0] np, nc, opnd;
        logic           npend, nsub;
        logic [2*W-1:0] nopnd;
        np = mp; nc = mc; npend = pend; nsub = pend_sub; nopnd = pend_opnd;
        opnd = {cmd_data_hi, cmd_data_lo};
        if (reset) begin
            np = {32'h0, 32'h0};
            nc = {RV_C, RV_C};
            npend = 1'b0;
        end else begin
            if (pend) begin
                if (!flush) np = pend_sub ? mp - pend_opnd : mp + pend_opnd;
                npend = 1'b0;
            end else if (cmd_valid && !flush) begin
                case (cmd_op)
                    3'd0: np[2*W-1:W] = cmd_data_hi;
                    3'd1: np[W-1:0]   = cmd_data_lo;
                    3'd2: np = opnd;
                    3'd3, 3'd4: begin
                        npend = 1'b1;
                        nsub  = (cmd_op == 3'd4);
                        nopnd = opnd;
                    end
                    default: ;
                endcase
            end
            if (cmd_valid && !flush) begin
                case (cmd_op)
                    3'd0: nc[2*W-1:W] = cmd_data_hi;
                    3'd1: nc[W-1:0]   = cmd_data_lo;
                    3'd2: nc = opnd;
                    3'd3: nc = mc + opnd;
                    3'd4: nc = mc - opnd;
                    default: ;
                endcase
            end
        end
        @(posedge clock);
        mp = np; mc = nc; pend = npend; pend_sub = nsub; pend_opnd = nopnd;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        set_cmd(1'b0, 3'd0, '0, '0);
        tick(); tick();
        reset = 1'b0;
        checks++; if ({hi_p, lo_p} !== 64'h0) begin errors++; $display("FAIL reset_hilo_p got %h want %h", {hi_p, lo_p}, 64'h0); end
        checks++; if ({busy_p, ready_p} !== 2'b01) begin errors++; $display("FAIL reset_busy_ready_p got %b want 01", {busy_p, ready_p}); end
        checks++; if ({hi_c, lo_c} !== {RV_C, RV_C}) begin errors++; $display("FAIL reset_hilo_c got %h want %h", {hi_c, lo_c}, {RV_C, RV_C}); end
        checks++; if ({busy_c, ready_c} !== 2'b01) begin errors++; $display("FAIL reset_busy_ready_c got %b want 01", {busy_c, ready_c}); end
    endtask

    task automatic test_back_to_back();
        set_cmd(1'b1, 3'd0, 32'hDEADBEEF, 32'h0);
        tick();
        checks++; if (hi_p !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_hi got %h want %h", hi_p, 32'hDEADBEEF); end
        set_cmd(1'b1, 3'd1, 32'h0, 32'h12345678);
        tick();
        checks++; if (lo_p !== 32'h12345678) begin errors++; $display("FAIL b2b_lo got %h want %h", lo_p, 32'h12345678); end
        checks++; if (hi_p !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_hi_kept got %h want %h", hi_p, 32'hDEADBEEF); end
        checks++; if ({hi_c, lo_c} !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL b2b_comb got %h want %h", {hi_c, lo_c}, 64'hDEADBEEF_12345678); end
        set_cmd(1'b0, 3'd0, '0, '0);
    endtask

    task automatic test_madd_carry();
        set_cmd(1'b1, 3'd2, 32'h0, 32'hFFFFFFFF);
        tick();
        set_cmd(1'b1, 3'd3, 32'h0, 32'h1);
        tick();
        checks++; if ({busy_p, ready_p} !== 2'b10) begin errors++; $display("FAIL madd_stall got %b want 10", {busy_p, ready_p}); end
        checks++; if ({hi_p, lo_p} !== 64'h0_FFFFFFFF) begin errors++; $display("FAIL madd_not_yet got %h want %h", {hi_p, lo_p}, 64'h0_FFFFFFFF); end
        checks++; if ({hi_c, lo_c} !== 64'h1_00000000) begin errors++; $display("FAIL madd_comb got %h want %h", {hi_c, lo_c}, 64'h1_00000000); end
        set_cmd(1'b0, 3'd0, '0, '0);
        tick();
        checks++; if ({busy_p, ready_p} !== 2'b01) begin errors++; $display("FAIL madd_release got %b want 01", {busy_p, ready_p}); end
        checks++; if ({hi_p, lo_p} !== 64'h1_00000000) begin errors++; $display("FAIL madd_carry got %h want %h", {hi_p, lo_p}, 64'h1_00000000); end
    endtask

    task automatic test_msub_stall();
        set_cmd(1'b1, 3'd2, 32'h0, 32'h0);
        tick();
        set_cmd(1'b1, 3'd4, 32'h0, 32'h1);
        tick();
        set_cmd(1'b1, 3'd1, 32'h0, 32'h5);
        tick();
        checks++; if ({hi_p, lo_p} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL msub_wrap got %h want %h", {hi_p, lo_p}, 64'hFFFFFFFF_FFFFFFFF); end
        checks++; if (ready_p !== 1'b1) begin errors++; $display("FAIL msub_ready got %b want 1", ready_p); end
        tick();
        checks++; if ({hi_p, lo_p} !== 64'hFFFFFFFF_00000005) begin errors++; $display("FAIL stall_write_lo got %h want %h", {hi_p, lo_p}, 64'hFFFFFFFF_00000005); end
        set_cmd(1'b0, 3'd0, '0, '0);
    endtask

    task automatic test_flush();
        set_cmd(1'b1, 3'd2, 32'h1, 32'h2);
        tick();
        set_cmd(1'b1, 3'd3, 32'h0, 32'h10);
        tick();
        set_cmd(1'b0, 3'd0, '0, '0);
        flush = 1'b1;
        tick();
        checks++; if ({hi_p, lo_p} !== 64'h1_00000002) begin errors++; $display("FAIL flush_acc got %h want %h", {hi_p, lo_p}, 64'h1_00000002); end
        checks++; if (busy_p !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy_p); end
        checks++; if ({hi_c, lo_c} !== 64'h1_00000012) begin errors++; $display("FAIL flush_comb got %h want %h", {hi_c, lo_c}, 64'h1_00000012); end
        set_cmd(1'b1, 3'd0, 32'hCAFEF00D, 32'h0);
        tick();
        checks++; if (hi_p !== 32'h1) begin errors++; $display("FAIL flush_write_hi got %h want %h", hi_p, 32'h1); end
        checks++; if (hi_c !== 32'h1) begin errors++; $display("FAIL flush_write_hi_c got %h want %h", hi_c, 32'h1); end
        flush = 1'b0;
        set_cmd(1'b0, 3'd0, '0, '0);
    endtask

    task automatic test_reset_mid_op();
        set_cmd(1'b1, 3'd2, 32'h7, 32'h7);
        tick();
        set_cmd(1'b1, 3'd3, 32'h0, 32'h1);
        tick();
        set_cmd(1'b0, 3'd0, '0, '0);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        checks++; if ({hi_p, lo_p} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo got %h want %h", {hi_p, lo_p}, 64'h0); end
        checks++; if (busy_p !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy_p); end
        tick();
        checks++; if ({hi_p, lo_p} !== 64'h0) begin errors++; $display("FAIL rst_mid_no_commit got %h want %h", {hi_p, lo_p}, 64'h0); end
    endtask

    task automatic test_comb_mode();
        set_cmd(1'b1, 3'd2, 32'h0, 32'h2);
        tick();
        set_cmd(1'b1, 3'd3, 32'h0, 32'h3);
        tick();
        checks++; if (lo_c !== 32'h5) begin errors++; $display("FAIL comb_madd_lo got %h want %h", lo_c, 32'h5); end
        checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL comb_busy got %b want 0", busy_c); end
        set_cmd(1'b1, 3'd6, 32'hFFFF, 32'hFFFF);
        tick();
        checks++; if ({hi_c, lo_c} !== 64'h0_00000005) begin errors++; $display("FAIL reserved_op_c got %h want %h", {hi_c, lo_c}, 64'h5); end
        checks++; if (busy_p !== 1'b0) begin errors++; $display("FAIL reserved_op_busy got %b want 0", busy_p); end
        set_cmd(1'b0, 3'd0, '0, '0);
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] dh, dl;
        for (int i = 0; i < 400; i++) begin
            dh = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            dl = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 2) : $urandom;
            set_cmd($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), dh, dl);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
            checks++; if ({hi_p, lo_p} !== mp) begin errors++; $display("FAIL rand_hilo_p[%0d] got %h want %h", i, {hi_p, lo_p}, mp); end
            checks++; if ({busy_p, ready_p} !== {pend, ~pend}) begin errors++; $display("FAIL rand_busy_p[%0d] got %b want %b", i, {busy_p, ready_p}, {pend, ~pend}); end
            checks++; if ({hi_c, lo_c} !== mc) begin errors++; $display("FAIL rand_hilo_c[%0d] got %h want %h", i, {hi_c, lo_c}, mc); end
            checks++; if ({busy_c, ready_c} !== 2'b01) begin errors++; $display("FAIL rand_busy_c[%0d] got %b want 01", i, {busy_c, ready_c}); end
        end
        reset = 1'b0; flush = 1'b0;
        set_cmd(1'b0, 3'd0, '0, '0);
    endtask

    initial begin
        mp = '0; mc = '0; pend = 1'b0; pend_sub = 1'b0; pend_opnd = '0;
        reset = 1'b1; flush = 1'b0;
        set_cmd(1'b0, 3'd0, '0, '0);
        #1;
        test_reset();
        test_back_to_back();
        test_madd_carry();
        test_msub_stall();
        test_flush();
        test_reset_mid_op();
        test_comb_mode();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
